// File: rtl/ffe_loader_pkg.sv
// Shared types and constants for the FFE weight loader.
// Holds the loader state encoding, the sat_count width and a saturating
// add helper used by the optional saturation counter
// (FFE_WEIGHT_LOADER_SAT_CNT_EN).
package ffe_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } loader_state_t;

    localparam int SAT_CNT_W = 8;

    // Adds inc to base and pins the result at the all-ones maximum.
    function automatic logic [SAT_CNT_W-1:0] sat_cnt_add(
        input logic [SAT_CNT_W-1:0] base,
        input int unsigned          inc
    );
        int unsigned sum;
        sum = 32'(base) + inc;
        if (sum > 32'((1 << SAT_CNT_W) - 1)) begin
            return '1;
        end
        return SAT_CNT_W'(sum);
    endfunction

endpackage

// File: rtl/ffe_tap_saturate.sv
// Clamps one signed tap estimate into a narrower signed weight.
// Values above the largest out_width value, or below the smallest, are
// pinned to that bound and flagged; in-range values pass through unchanged.
module ffe_tap_saturate #(
    parameter int in_width  = 10,
    parameter int out_width = 8
) (
    input  logic signed [in_width-1:0]  din,
    output logic signed [out_width-1:0] dout,
    output logic                        clamped
);

    localparam logic signed [in_width-1:0] MAX_V =
        in_width'((64'sd1 <<< (out_width - 1)) - 64'sd1);
    // Two's complement: ~MAX equals -MAX-1, the most negative weight.
    localparam logic signed [in_width-1:0] MIN_V = ~MAX_V;

    // Compare in the wide domain, then truncate the (now in-range) value.
    always_comb begin
        dout    = din[out_width-1:0];
        clamped = 1'b0;
        if (din > MAX_V) begin
            dout    = MAX_V[out_width-1:0];
            clamped = 1'b1;
        end else if (din < MIN_V) begin
            dout    = MIN_V[out_width-1:0];
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/ffe_weight_loader.sv
// FFE weight loader: snapshots saturated tap estimates on update_req and
// streams them into the weight store, channel by channel in ascending
// order, honouring wr_ready back-pressure. Unmasked channels are skipped
// at no cycle cost.
// Optional feature: define FFE_WEIGHT_LOADER_SAT_CNT_EN to build the
// saturating count of clamped taps on sat_count; otherwise it reads 0.
module ffe_weight_loader
    import ffe_loader_pkg::*;
#(
    parameter int est_depth       = 10,
    parameter int ffe_bitwidth    = 10,
    parameter int weight_bitwidth = 8,
    parameter int num_chan        = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic signed [ffe_bitwidth-1:0]    ffe_est [est_depth],
    input  logic                              update_req,
    input  logic [num_chan-1:0]               chan_mask,
    input  logic                              abort,
    input  logic                              clr_sat,
    input  logic                              wr_ready,
    output logic                              wr_en,
    output logic [$clog2(num_chan)-1:0]       wr_chan,
    output logic [$clog2(est_depth)-1:0]      wr_tap,
    output logic signed [weight_bitwidth-1:0] wr_data,
    output logic                              busy,
    output logic                              done,
    output logic                              sat_flag,
    output logic [SAT_CNT_W-1:0]              sat_count
);

    localparam int CHAN_W = $clog2(num_chan);
    localparam int TAP_W  = $clog2(est_depth);
    localparam int CNT_W  = $clog2(est_depth + 1);

    loader_state_t state, next_state;

    logic signed [weight_bitwidth-1:0] sat_est [est_depth];
    logic [est_depth-1:0]              clamped;
    logic signed [weight_bitwidth-1:0] snap    [est_depth];
    logic [num_chan-1:0]               mask_q;
    logic [CHAN_W-1:0]                 chan_q;
    logic [TAP_W-1:0]                  tap_q;

    logic              snap_en;
    logic              accept;
    logic              last_tap;
    logic              mask_any;
    logic              has_next;
    logic [CHAN_W-1:0] first_chan;
    logic [CHAN_W-1:0] next_chan;

    for (genvar g = 0; g < est_depth; g++) begin : g_sat
        ffe_tap_saturate #(
            .in_width  (ffe_bitwidth),
            .out_width (weight_bitwidth)
        ) u_sat (
            .din     (ffe_est[g]),
            .dout    (sat_est[g]),
            .clamped (clamped[g])
        );
    end

    assign snap_en  = (state == IDLE) && update_req;
    assign accept   = (state == WRITE) && wr_ready && !abort;
    assign last_tap = (tap_q == TAP_W'(est_depth - 1));

    // Lowest set bit of the live mask (starting channel) and the next masked
    // channel above the current one; descending scans let the lowest win.
    always_comb begin
        first_chan = '0;
        mask_any   = 1'b0;
        next_chan  = '0;
        has_next   = 1'b0;
        for (int i = num_chan - 1; i >= 0; i--) begin
            if (chan_mask[i]) begin
                first_chan = CHAN_W'(i);
                mask_any   = 1'b1;
            end
            if (mask_q[i] && (i > int'(chan_q))) begin
                next_chan = CHAN_W'(i);
                has_next  = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort wins over an accepted write.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (update_req) begin
                    next_state = mask_any ? WRITE : DONE;
                end
            end
            WRITE: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (accept && last_tap && !has_next) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Snapshot capture and write-address walk; address only moves on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < est_depth; i++) begin
                snap[i] <= '0;
            end
            mask_q <= '0;
            chan_q <= '0;
            tap_q  <= '0;
        end else if (snap_en) begin
            for (int i = 0; i < est_depth; i++) begin
                snap[i] <= sat_est[i];
            end
            mask_q <= chan_mask;
            chan_q <= first_chan;
            tap_q  <= '0;
        end else if (accept) begin
            if (last_tap) begin
                if (has_next) begin
                    chan_q <= next_chan;
                    tap_q  <= '0;
                end
            end else begin
                tap_q <= tap_q + 1'b1;
            end
        end
    end

    // Sticky saturation flag; a new clamp beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (snap_en && (|clamped)) begin
            sat_flag <= 1'b1;
        end else if (clr_sat) begin
            sat_flag <= 1'b0;
        end
    end

`ifdef FFE_WEIGHT_LOADER_SAT_CNT_EN
    logic [CNT_W-1:0]     clamp_num;
    logic [SAT_CNT_W-1:0] sat_cnt_q;

    // Number of taps clamped in the current estimate set.
    always_comb begin
        clamp_num = '0;
        for (int i = 0; i < est_depth; i++) begin
            clamp_num = clamp_num + CNT_W'(clamped[i]);
        end
    end

    // Running clamp count; a clear in the snapshot cycle drops the old total
    // before the new clamps are added.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else if (snap_en) begin
            sat_cnt_q <= sat_cnt_add(clr_sat ? '0 : sat_cnt_q, 32'(clamp_num));
        end else if (clr_sat) begin
            sat_cnt_q <= '0;
        end
    end

    assign sat_count = sat_cnt_q;
`else
    assign sat_count = '0;
`endif

    assign wr_en   = (state == WRITE);
    assign wr_chan = chan_q;
    assign wr_tap  = tap_q;
    assign wr_data = snap[tap_q];
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_ffe_weight_loader.sv
// Scoreboard testbench for ffe_weight_loader. Each accepted update pushes
// the expected write sequence (ascending channel, ascending tap, clamped
// value) into a queue; a monitor compares every presented write against the
// queue head and pops on acceptance. Honours FFE_WEIGHT_LOADER_SAT_CNT_EN.
module tb_ffe_weight_loader;

    localparam int EST = 10;
    localparam int FB  = 10;
    localparam int WB  = 8;
    localparam int NCH = 16;
    localparam int WMAX = (1 << (WB - 1)) - 1;
    localparam int WMIN = -(1 << (WB - 1));

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [FB-1:0] ffe_est [EST];
    logic                 update_req;
    logic [NCH-1:0]       chan_mask;
    logic                 abort;
    logic                 clr_sat;
    logic                 wr_ready;
    logic                 wr_en;
    logic [3:0]           wr_chan;
    logic [3:0]           wr_tap;
    logic signed [WB-1:0] wr_data;
    logic                 busy;
    logic                 done;
    logic                 sat_flag;
    logic [7:0]           sat_count;

    typedef struct {
        int chan;
        int tap;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  done_pending = 0;
    int  accepted = 0;
    int  wr_cycles = 0;
    bit  expect_done_next = 1'b0;
    bit  exp_sat_flag = 1'b0;
    int  exp_sat_cnt = 0;
    int  ready_mode = 0;
    int  ready_phase = 0;
    int  est_vals [EST];

    ffe_weight_loader #(
        .est_depth       (EST),
        .ffe_bitwidth    (FB),
        .weight_bitwidth (WB),
        .num_chan        (NCH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ffe_est    (ffe_est),
        .update_req (update_req),
        .chan_mask  (chan_mask),
        .abort      (abort),
        .clr_sat    (clr_sat),
        .wr_ready   (wr_ready),
        .wr_en      (wr_en),
        .wr_chan    (wr_chan),
        .wr_tap     (wr_tap),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .sat_flag   (sat_flag),
        .sat_count  (sat_count)
    );

    always #5 clk = ~clk;

    function automatic int sat_ref(input int v);
        if (v > WMAX) return WMAX;
        if (v < WMIN) return WMIN;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_sat_flag"}, sat_flag, exp_sat_flag);
        checkOutput({tag, "_sat_count"}, sat_count, exp_sat_cnt);
    endtask

    task automatic randomEst(input int span);
        for (int t = 0; t < EST; t++) begin
            est_vals[t] = $urandom_range(0, 2 * span) - span;
        end
    endtask

    task automatic scrambleLive();
        for (int t = 0; t < EST; t++) begin
            ffe_est[t] = FB'($urandom);
        end
    endtask

    // Drives one update_req pulse from est_vals and records the expected writes.
    task automatic applyStimulus(input logic [NCH-1:0] mask, input bit with_clr);
        int nclamp;
        nclamp = 0;
        for (int t = 0; t < EST; t++) begin
            ffe_est[t] = FB'(est_vals[t]);
            if (sat_ref(est_vals[t]) != est_vals[t]) nclamp++;
        end
        chan_mask  = mask;
        update_req = 1'b1;
        clr_sat    = with_clr;
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                for (int t = 0; t < EST; t++) begin
                    exp_q.push_back('{c, t, sat_ref(est_vals[t])});
                end
            end
        end
        if (nclamp > 0) exp_sat_flag = 1'b1;
        else if (with_clr) exp_sat_flag = 1'b0;
`ifdef FFE_WEIGHT_LOADER_SAT_CNT_EN
        exp_sat_cnt = (with_clr ? 0 : exp_sat_cnt) + nclamp;
        if (exp_sat_cnt > 255) exp_sat_cnt = 255;
`else
        exp_sat_cnt = 0;
`endif
        done_pending++;
        @(posedge clk); #1;
        update_req = 1'b0;
        clr_sat    = 1'b0;
        chan_mask  = NCH'($urandom);
    endtask

    // Waits for the outstanding update to finish while the live estimates churn.
    task automatic waitDone(input string tag, input int budget);
        for (int i = 0; i < budget && done_pending != 0; i++) begin
            scrambleLive();
            @(posedge clk); #1;
        end
        checkOutput({tag, "_complete"}, done_pending, 0);
        checkOutput({tag, "_queue_drained"}, exp_q.size(), 0);
        exp_q.delete();
        done_pending = 0;
    endtask

    task automatic clearSat();
        clr_sat = 1'b1;
        @(posedge clk); #1;
        clr_sat = 1'b0;
        exp_sat_flag = 1'b0;
        exp_sat_cnt  = 0;
    endtask

    // wr_ready generator: always ready, random, or the 1,0,0,1 stall pattern.
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1: wr_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    wr_ready = (ready_phase == 0) || (ready_phase == 3);
                    ready_phase = (ready_phase + 1) % 4;
                end
                default: wr_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares every presented write with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expect_done_next = 1'b0;
                continue;
            end
            if (expect_done_next) begin
                checkOutput("done_after_last_write", done, 1);
                expect_done_next = 1'b0;
            end
            if (done) begin
                checkOutput("done_expected", (done_pending > 0) && (exp_q.size() == 0), 1);
                if (done_pending > 0) done_pending--;
            end
            if (wr_en) begin
                wr_cycles++;
                if (exp_q.size() == 0) begin
                    checkOutput("wr_en_unexpected", wr_en, 0);
                end else begin
                    checkOutput("wr_chan", wr_chan, exp_q[0].chan);
                    checkOutput("wr_tap", wr_tap, exp_q[0].tap);
                    checkOutput("wr_data", wr_data, exp_q[0].data);
                    if (wr_ready && !abort) begin
                        void'(exp_q.pop_front());
                        accepted++;
                        if (exp_q.size() == 0) expect_done_next = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        logic [NCH-1:0] m;

        rst_n = 1'b0;
        update_req = 1'b0;
        chan_mask = '0;
        abort = 1'b0;
        clr_sat = 1'b0;
        for (int t = 0; t < EST; t++) ffe_est[t] = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_wr_chan", wr_chan, 0);
        checkOutput("rst_wr_tap", wr_tap, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_done", done, 0);
        checkStatus("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All taps 5, channels 0 and 2: 20 writes.
        for (int t = 0; t < EST; t++) est_vals[t] = 5;
        base = wr_cycles;
        applyStimulus(16'h0005, 1'b0);
        waitDone("mask5", 100);
        checkOutput("mask5_wr_cycles", wr_cycles - base, 20);
        checkStatus("mask5");

        // Full mask, always ready: exactly num_chan*est_depth write cycles.
        randomEst(100);
        base = wr_cycles;
        applyStimulus('1, 1'b0);
        waitDone("full", 400);
        checkOutput("full_wr_cycles", wr_cycles - base, NCH * EST);
        checkStatus("full");

        // Saturation at both bounds.
        randomEst(100);
        est_vals[3] = 200;
        est_vals[4] = -300;
        applyStimulus(16'h0100 | NCH'($urandom), 1'b0);
        waitDone("sat", 400);
        checkStatus("sat");
        clearSat();
        checkStatus("sat_clr");

        // 1,0,0,1 stall pattern with live estimates changing.
        ready_mode = 2;
        randomEst(500);
        applyStimulus(NCH'($urandom) | 16'h0001, 1'b0);
        waitDone("stall", 1000);
        checkStatus("stall");

        // Empty mask: straight to DONE for one cycle, no writes.
        ready_mode = 0;
        randomEst(50);
        applyStimulus('0, 1'b0);
        checkOutput("mask0_done", done, 1);
        checkOutput("mask0_busy", busy, 1);
        checkOutput("mask0_wr_en", wr_en, 0);
        @(posedge clk); #1;
        checkOutput("mask0_done_clear", done, 0);
        waitDone("mask0", 5);
        checkStatus("mask0");

        // Random updates with random back-pressure.
        ready_mode = 1;
        for (int n = 0; n < 6; n++) begin
            randomEst(($urandom_range(0, 1) != 0) ? 511 : 120);
            m = NCH'($urandom);
            if ($urandom_range(0, 4) == 0) m = '0;
            applyStimulus(m, 1'b0);
            waitDone("rand", 1200);
            checkStatus("rand");
        end

        // update_req during WRITE is dropped; only one done pulse.
        ready_mode = 0;
        randomEst(100);
        applyStimulus(16'h0012, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        randomEst(500);
        for (int t = 0; t < EST; t++) ffe_est[t] = FB'(est_vals[t]);
        chan_mask  = '1;
        update_req = 1'b1;
        @(posedge clk); #1;
        update_req = 1'b0;
        waitDone("ignored_req", 100);
        repeat (30) @(posedge clk);
        #1;
        checkStatus("ignored_req");

        // clr_sat coinciding with a new clamp leaves the flag set.
        randomEst(50);
        est_vals[0] = 400;
        applyStimulus(16'h8000, 1'b1);
        waitDone("clr_and_sat", 100);
        checkStatus("clr_and_sat");

        // Abort on the 7th write: back to IDLE, no done pulse.
        randomEst(300);
        applyStimulus(NCH'($urandom) | 16'h0004, 1'b0);
        base = accepted;
        for (int i = 0; i < 50 && accepted != base + 6; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("abort_six_written", accepted - base, 6);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        done_pending = 0;
        checkOutput("abort_wr_en", wr_en, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("abort_no_extra_writes", accepted - base, 6);
        checkStatus("abort");

        // Asynchronous reset in the middle of a WRITE.
        randomEst(500);
        applyStimulus('1, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        done_pending = 0;
        exp_sat_flag = 1'b0;
        exp_sat_cnt  = 0;
        checkOutput("arst_wr_en", wr_en, 0);
        checkOutput("arst_wr_chan", wr_chan, 0);
        checkOutput("arst_wr_tap", wr_tap, 0);
        checkOutput("arst_wr_data", wr_data, 0);
        checkOutput("arst_done", done, 0);
        checkStatus("arst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkStatus("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ffe_weight_loader.md
FFE_WEIGHT_LOADER -- requirements
Module: ffe_weight_loader

Interface
REQ-001 SHALL have parameter est_depth, default 10, number of FFE taps.
REQ-002 SHALL have parameter ffe_bitwidth, default 10, width of incoming tap estimates.
REQ-003 SHALL have parameter weight_bitwidth, default 8, width of written weights; weight_bitwidth <= ffe_bitwidth.
REQ-004 SHALL have parameter num_chan, default 16, number of FFE channels.
REQ-005 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ffe_est  input  signed [ffe_bitwidth-1:0] x est_depth  tap estimates from the FFE estimator.
REQ-008 SHALL have port update_req  input  1  single-cycle request to commit the estimates.
REQ-009 SHALL have port chan_mask  input  num_chan  channels to update (1 = write).
REQ-010 SHALL have port abort  input  1  synchronous cancel of an update in progress.
REQ-011 SHALL have port clr_sat  input  1  clears sat_flag.
REQ-012 SHALL have port wr_ready  input  1  weight store accepts a write this cycle.
REQ-013 SHALL have port wr_en  output  1  write valid.
REQ-014 SHALL have port wr_chan  output  $clog2(num_chan)  target channel.
REQ-015 SHALL have port wr_tap  output  $clog2(est_depth)  target tap.
REQ-016 SHALL have port wr_data  output  signed [weight_bitwidth-1:0]  saturated weight.
REQ-017 SHALL have port busy, done, sat_flag  output  1 each  status.
REQ-018 SHALL have port sat_count  output  8  number of saturated taps.

Function
REQ-019 SHALL implement the states IDLE, WRITE and DONE.
REQ-020 In IDLE with update_req=1, SHALL on that edge register all ffe_est taps saturated to weight_bitwidth, plus chan_mask; next state is WRITE, or DONE if the registered mask is zero.
REQ-021 SHALL saturate each tap above 2^(weight_bitwidth-1)-1 to that value and each tap below -2^(weight_bitwidth-1) to that value; in-range taps SHALL pass unchanged.
REQ-022 SHALL set sat_flag on the snapshot edge if any tap was clamped; sat_flag is sticky until clr_sat; a simultaneous set and clr_sat SHALL leave sat_flag at 1.
REQ-023 In WRITE, SHALL assert wr_en with wr_chan/wr_tap/wr_data taken from the snapshot, never from live ffe_est.
REQ-024 Write order SHALL be ascending channel, and ascending tap 0..est_depth-1 within each channel; unmasked channels SHALL cost zero cycles.
REQ-025 Address and data SHALL advance only on an edge with wr_en&&wr_ready; while wr_ready=0 they SHALL hold stable.
REQ-026 After the accepted write of the last tap of the highest masked channel, SHALL enter DONE; DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-027 busy SHALL equal (state != IDLE).
REQ-028 update_req outside IDLE SHALL be ignored; it SHALL not queue.
REQ-029 abort in WRITE SHALL return to IDLE on the next edge with wr_en=0 and no done pulse; abort SHALL take priority over a simultaneous accepted write; abort in IDLE/DONE SHALL be ignored.
REQ-030 wr_en SHALL be 0 in IDLE and in DONE.
REQ-031 A full update with all channels masked and wr_ready held at 1 SHALL take num_chan*est_depth WRITE cycles.

Reset
REQ-032 rst_n low SHALL force the state to IDLE and clear the snapshot, counters, wr_en, done, busy, sat_flag and sat_count to 0 immediately; this SHALL hold even in the middle of a WRITE.
REQ-033 wr_chan, wr_tap and wr_data SHALL reset to 0.

Configuration
REQ-034 With FFE_WEIGHT_LOADER_SAT_CNT_EN defined, sat_count SHALL add the number of clamped taps at each snapshot, saturating at 255, and clear on clr_sat.
REQ-035 Without FFE_WEIGHT_LOADER_SAT_CNT_EN, sat_count SHALL be tied to 0 and no counter logic SHALL be built; sat_flag is unaffected.

Structure
REQ-036 The state enum (loader_state_t, 2 bits) and the sat_count width constant SHALL live in ffe_loader_pkg.
REQ-037 Per-tap clamping SHALL be a sub-module, ffe_tap_saturate (parameters in_width and out_width), instantiated est_depth times.

Verification
REQ-038 ffe_est all 5, chan_mask=16'h0005, wr_ready=1, update_req pulse -> 20 writes (ch0 taps0-9, then ch2 taps0-9), data 5, done pulse one cycle after the last write.
REQ-039 tap3=200, tap4=-300, weight_bitwidth=8 -> wr_data 127 and -128, sat_flag=1, sat_count=2 (macro on) or 0 (macro off).
REQ-040 wr_ready toggling 1,0,0,1 during WRITE; ffe_est changed mid-update -> outputs hold during stalls, data equals the snapshot.
REQ-041 chan_mask=0 with update_req -> DONE on the next cycle, no wr_en, done=1 for one cycle.
REQ-042 abort at the 7th write -> IDLE, no done pulse; then rst_n low mid-update -> all outputs 0 asynchronously.
REQ-043 update_req during WRITE -> ignored, one done pulse only; clr_sat together with a new saturation -> sat_flag stays 1.
